// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready wrapper around the combinational 8-bit ALU.
// It registers one operation, waits SETTLE_CYCLES edges for the ALU to settle,
// captures sum/carry/zero, and holds the result until downstream accepts it.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned WIDTH         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [3:0]       in_sel,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_zero,
  output logic             busy,
  output logic [7:0]       op_count
);

  localparam int unsigned SEL_W   = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned OPCNT_W = 8;

  // Reject illegal configurations at elaboration.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
  end
  if (WIDTH != 8) begin : g_bad_width
    $error("alu_op_sequencer: WIDTH must be 8");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   alu_x_q, alu_x_d;
  logic [WIDTH-1:0]   alu_y_q, alu_y_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0]   out_sum_q, out_sum_d;
  logic               out_carry_q, out_carry_d;
  logic               out_zero_q, out_zero_d;
  logic               out_valid_q, out_valid_d;
  logic [OPCNT_W-1:0] op_count_q, op_count_d;

  // Upstream may hand over an op when idle, or when the held result leaves this cycle.
  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    alu_sel_d   = alu_sel_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_zero_d  = out_zero_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          alu_x_d   = in_x;
          alu_y_d   = in_y;
          alu_sel_d = in_sel;
          cnt_d     = CNT_W'(SETTLE_CYCLES);
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_sum_d   = alu_sum;
          out_carry_d = alu_carry;
          out_zero_d  = (alu_sum == '0);
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          op_count_d  = op_count_q + OPCNT_W'(1);
          out_valid_d = 1'b0;
          if (in_valid) begin
            alu_x_d   = in_x;
            alu_y_d   = in_y;
            alu_sel_d = in_sel;
            cnt_d     = CNT_W'(SETTLE_CYCLES);
            state_d   = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      alu_sel_q   <= '0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      alu_sel_q   <= alu_sel_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_zero_q  <= out_zero_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_sel   = alu_sel_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_zero  = out_zero_q;
  assign out_valid = out_valid_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: three instances (settle 1, 4 and 3) driven by
// directed steps; instance A results go through a queue-based scoreboard.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] sum;
    logic       carry;
    logic       zero;
  } res_t;

  res_t        sb[$];
  int unsigned exp_cnt_a = 0;

  // Reference ALU: add, subtract, and, xor, and a select-dependent xor.
  function automatic logic [8:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                       input logic [3:0] sel);
    case (sel)
      4'h0:    alu_f = {1'b0, x} + {1'b0, y};
      4'h1:    alu_f = {1'b0, x} - {1'b0, y};
      4'h2:    alu_f = {1'b0, x & y};
      4'h3:    alu_f = {1'b0, x ^ y};
      default: alu_f = {1'b0, x ^ {sel, sel}};
    endcase
  endfunction

  // Instance A: SETTLE_CYCLES = 1
  logic       rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [7:0] in_x_a, in_y_a, alu_x_a, alu_y_a, alu_sum_a, out_sum_a, op_count_a;
  logic [3:0] in_sel_a, alu_sel_a;
  logic       alu_carry_a, out_carry_a, out_zero_a, busy_a;
  assign {alu_carry_a, alu_sum_a} = alu_f(alu_x_a, alu_y_a, alu_sel_a);

  alu_op_sequencer #(.SETTLE_CYCLES(1), .WIDTH(8)) u_dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_x(in_x_a), .in_y(in_y_a), .in_sel(in_sel_a),
    .alu_x(alu_x_a), .alu_y(alu_y_a), .alu_sel(alu_sel_a),
    .alu_sum(alu_sum_a), .alu_carry(alu_carry_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_sum(out_sum_a), .out_carry(out_carry_a), .out_zero(out_zero_a),
    .busy(busy_a), .op_count(op_count_a)
  );

  // Instances B (SETTLE_CYCLES = 4) and C (SETTLE_CYCLES = 3) share stimulus.
  logic       rst_b, rst_c, in_valid_bc, out_ready_bc;
  logic [7:0] in_x_bc, in_y_bc;
  logic [3:0] in_sel_bc;
  logic       in_ready_b, out_valid_b, alu_carry_b, out_carry_b, out_zero_b, busy_b;
  logic [7:0] alu_x_b, alu_y_b, alu_sum_b, out_sum_b, op_count_b;
  logic [3:0] alu_sel_b;
  logic       in_ready_c, out_valid_c, alu_carry_c, out_carry_c, out_zero_c, busy_c;
  logic [7:0] alu_x_c, alu_y_c, alu_sum_c, out_sum_c, op_count_c;
  logic [3:0] alu_sel_c;
  assign {alu_carry_b, alu_sum_b} = alu_f(alu_x_b, alu_y_b, alu_sel_b);
  assign {alu_carry_c, alu_sum_c} = alu_f(alu_x_c, alu_y_c, alu_sel_c);

  alu_op_sequencer #(.SETTLE_CYCLES(4), .WIDTH(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_bc), .in_ready(in_ready_b),
    .in_x(in_x_bc), .in_y(in_y_bc), .in_sel(in_sel_bc),
    .alu_x(alu_x_b), .alu_y(alu_y_b), .alu_sel(alu_sel_b),
    .alu_sum(alu_sum_b), .alu_carry(alu_carry_b),
    .out_valid(out_valid_b), .out_ready(out_ready_bc),
    .out_sum(out_sum_b), .out_carry(out_carry_b), .out_zero(out_zero_b),
    .busy(busy_b), .op_count(op_count_b)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3), .WIDTH(8)) u_dut_c (
    .clk(clk), .rst(rst_c), .in_valid(in_valid_bc), .in_ready(in_ready_c),
    .in_x(in_x_bc), .in_y(in_y_bc), .in_sel(in_sel_bc),
    .alu_x(alu_x_c), .alu_y(alu_y_c), .alu_sel(alu_sel_c),
    .alu_sum(alu_sum_c), .alu_carry(alu_carry_c),
    .out_valid(out_valid_c), .out_ready(out_ready_bc),
    .out_sum(out_sum_c), .out_carry(out_carry_c), .out_zero(out_zero_c),
    .busy(busy_c), .op_count(op_count_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard A's handshakes just before the edge, return #1 after it.
  task automatic step(output bit acc);
    logic [8:0] r;
    res_t       e;
    bit         was_rst;
    #1;
    was_rst = rst_a;
    acc = !rst_a && in_valid_a && in_ready_a;
    if (!rst_a && out_valid_a && out_ready_a) begin
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_sum",   32'(out_sum_a),   32'(e.sum));
        chk("sb_carry", 32'(out_carry_a), 32'(e.carry));
        chk("sb_zero",  32'(out_zero_a),  32'(e.zero));
      end
      exp_cnt_a = (exp_cnt_a + 1) % 256;
    end
    if (acc) begin
      r = alu_f(in_x_a, in_y_a, in_sel_a);
      sb.push_back({r[7:0], r[8], (r[7:0] == 8'h00)});
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      sb.delete();
      exp_cnt_a = 0;
    end
  endtask

  task automatic tick();
    bit d;
    step(d);
  endtask

  initial begin
    bit acc;
    int sent;
    int guard;

    rst_a = 1'b1; in_valid_a = 1'b1; in_x_a = 8'hAA; in_y_a = 8'h55; in_sel_a = 4'h7;
    out_ready_a = 1'b1;
    rst_b = 1'b1; rst_c = 1'b1; in_valid_bc = 1'b0; in_x_bc = 8'h00; in_y_bc = 8'h00;
    in_sel_bc = 4'h0; out_ready_bc = 1'b1;

    // Reset held two cycles with in_valid high
    tick();
    tick();
    chk("rst_in_ready",  32'(in_ready_a),  32'd1);
    chk("rst_busy",      32'(busy_a),      32'd0);
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_alu_x",     32'(alu_x_a),     32'h00);
    chk("rst_alu_y",     32'(alu_y_a),     32'h00);
    chk("rst_alu_sel",   32'(alu_sel_a),   32'h0);
    chk("rst_out_sum",   32'(out_sum_a),   32'h00);
    chk("rst_out_carry", 32'(out_carry_a), 32'd0);
    chk("rst_out_zero",  32'(out_zero_a),  32'd0);
    chk("rst_op_count",  32'(op_count_a),  32'h00);
    rst_a = 1'b0; in_valid_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready_a), 32'd1);

    // Single add, one-cycle latency
    in_x_a = 8'h0F; in_y_a = 8'h01; in_sel_a = 4'h0; in_valid_a = 1'b1;
    step(acc);
    chk("t2_accept", 32'(acc), 32'd1);
    in_valid_a = 1'b0;
    chk("t2_settle_valid", 32'(out_valid_a), 32'd0);
    chk("t2_settle_busy",  32'(busy_a),      32'd1);
    chk("t2_settle_ready", 32'(in_ready_a),  32'd0);
    chk("t2_alu_x",        32'(alu_x_a),     32'h0F);
    chk("t2_alu_y",        32'(alu_y_a),     32'h01);
    tick();
    chk("t2_out_valid", 32'(out_valid_a), 32'd1);
    chk("t2_out_sum",   32'(out_sum_a),   32'h10);
    chk("t2_out_carry", 32'(out_carry_a), 32'd0);
    chk("t2_out_zero",  32'(out_zero_a),  32'd0);
    chk("t2_hold_ready", 32'(in_ready_a), 32'd1);
    tick();
    chk("t2_done_valid", 32'(out_valid_a), 32'd0);
    chk("t2_op_count",   32'(op_count_a),  32'h01);
    chk("t2_sum_retained", 32'(out_sum_a), 32'h10);
    chk("t2_idle_busy",  32'(busy_a),      32'd0);

    // Carry out with zero result
    in_x_a = 8'hFF; in_y_a = 8'h01; in_sel_a = 4'h0; in_valid_a = 1'b1;
    step(acc);
    chk("t3_accept", 32'(acc), 32'd1);
    in_valid_a = 1'b0;
    tick();
    chk("t3_out_sum",   32'(out_sum_a),   32'h00);
    chk("t3_out_carry", 32'(out_carry_a), 32'd1);
    chk("t3_out_zero",  32'(out_zero_a),  32'd1);
    tick();
    chk("t3_op_count", 32'(op_count_a), 32'h02);

    // Backpressure with the next op waiting, then back-to-back load
    out_ready_a = 1'b0;
    in_x_a = 8'h12; in_y_a = 8'h34; in_sel_a = 4'h1; in_valid_a = 1'b1;
    step(acc);
    chk("t4_accept1", 32'(acc), 32'd1);
    in_x_a = 8'h80; in_y_a = 8'h80; in_sel_a = 4'h0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_bp_valid", 32'(out_valid_a), 32'd1);
      chk("t4_bp_ready", 32'(in_ready_a),  32'd0);
      chk("t4_bp_alu_x", 32'(alu_x_a),     32'h12);
      chk("t4_bp_sel",   32'(alu_sel_a),   32'h1);
      chk("t4_bp_sum",   32'(out_sum_a),   32'hDE);
      chk("t4_bp_carry", 32'(out_carry_a), 32'd1);
      tick();
    end
    out_ready_a = 1'b1;
    step(acc);
    chk("t4_accept2", 32'(acc), 32'd1);
    in_valid_a = 1'b0;
    chk("t4_b2b_alu_x", 32'(alu_x_a),     32'h80);
    chk("t4_b2b_sel",   32'(alu_sel_a),   32'h0);
    chk("t4_b2b_valid", 32'(out_valid_a), 32'd0);
    chk("t4_op_count3", 32'(op_count_a),  32'h03);
    tick();
    chk("t4_out_sum",   32'(out_sum_a),   32'h00);
    chk("t4_out_carry", 32'(out_carry_a), 32'd1);
    tick();
    chk("t4_op_count4", 32'(op_count_a), 32'h04);

    // Settle latency of 4 (B) and reset mid-settle (C)
    in_x_bc = 8'hFF; in_y_bc = 8'h01; in_sel_bc = 4'h0; in_valid_bc = 1'b1;
    tick();
    in_valid_bc = 1'b0;
    chk("t3b_e0_valid", 32'(out_valid_b), 32'd0);
    chk("t5_alu_x_loaded", 32'(alu_x_c),  32'hFF);
    tick();
    chk("t3b_e1_valid", 32'(out_valid_b), 32'd0);
    chk("t5_e1_valid",  32'(out_valid_c), 32'd0);
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    chk("t3b_e2_valid", 32'(out_valid_b), 32'd0);
    chk("t5_rst_valid", 32'(out_valid_c), 32'd0);
    chk("t5_rst_alu_x", 32'(alu_x_c),     32'h00);
    chk("t5_rst_busy",  32'(busy_c),      32'd0);
    tick();
    chk("t3b_e3_valid", 32'(out_valid_b), 32'd0);
    chk("t5_e3_valid",  32'(out_valid_c), 32'd0);
    tick();
    chk("t3b_e4_valid", 32'(out_valid_b), 32'd1);
    chk("t3b_e4_sum",   32'(out_sum_b),   32'h00);
    chk("t3b_e4_carry", 32'(out_carry_b), 32'd1);
    chk("t3b_e4_zero",  32'(out_zero_b),  32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_never_valid", 32'(out_valid_c), 32'd0);
    end
    chk("t3b_op_count", 32'(op_count_b), 32'h01);
    chk("t5_op_count",  32'(op_count_c), 32'h00);
    chk("t5_alu_x",     32'(alu_x_c),    32'h00);

    // 257 back-to-back ops, op_count wraps to 1
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("t6_rst_op_count", 32'(op_count_a), 32'h00);
    sent = 0;
    guard = 0;
    in_x_a = 8'($urandom_range(0, 255)); in_y_a = 8'($urandom_range(0, 255));
    in_sel_a = 4'($urandom_range(0, 15)); in_valid_a = 1'b1;
    while (sent < 257 && guard < 2000) begin
      step(acc);
      guard++;
      if (acc) begin
        sent++;
        if (sent < 257) begin
          in_x_a = 8'($urandom_range(0, 255)); in_y_a = 8'($urandom_range(0, 255));
          in_sel_a = 4'($urandom_range(0, 15));
        end else begin
          in_valid_a = 1'b0;
        end
      end
    end
    chk("t6_sent", 32'(sent), 32'd257);
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("t6_drained", 32'(sb.size()), 32'd0);
    chk("t6_op_count_wrap", 32'(op_count_a), 32'h01);
    chk("t6_op_count_model", 32'(op_count_a), 32'(exp_cnt_a));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Registered front/back end for the 8-bit ripple ALU. Accepts one operation (x, y, sel) per valid/ready handshake and holds the operands stable on the ALU inputs for a programmable settle time. It then captures the ALU sum/carry with a zero flag and presents the result downstream on a second valid/ready handshake. It turns the combinational ALU into a flow-controlled pipeline element.

Parameters:
SETTLE_CYCLES, 1, clock edges between operand launch and result capture; legal range 1..15.
WIDTH, 8, datapath width; fixed at 8 to match the ALU.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream operation valid
in_ready  output  1  sequencer can accept an operation this cycle
in_x  input  8  operand x
in_y  input  8  operand y
in_sel  input  4  ALU select, passed through unchanged
alu_x  output  8  registered operand to ALU x
alu_y  output  8  registered operand to ALU y
alu_sel  output  4  registered select to ALU sel
alu_sum  input  8  ALU sum result
alu_carry  input  1  ALU carry out
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  8  captured sum
out_carry  output  1  captured carry
out_zero  output  1  1 when captured sum == 0x00
busy  output  1  state != IDLE
op_count  output  8  completed (downstream-accepted) operations, wraps 0xFF->0x00

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset: state=IDLE; alu_x, alu_y, alu_sel, out_sum, out_carry, out_zero, out_valid, op_count, settle counter all 0. After reset, in_ready=1 and busy=0.
- FSM states: IDLE, SETTLE, HOLD.
- in_ready = (state==IDLE) or (state==HOLD and out_ready). Combinational; it never depends on in_valid.
- IDLE: on in_valid&in_ready, register in_x/in_y/in_sel into alu_x/alu_y/alu_sel, load the counter with SETTLE_CYCLES, and go to SETTLE.
- SETTLE: in_ready=0. Each edge decrements the counter. On the edge where the counter == 1, capture alu_sum->out_sum, alu_carry->out_carry and (alu_sum==0)->out_zero, set out_valid=1, and go to HOLD.
- Latency: with SETTLE_CYCLES=N, out_valid rises N edges after the accepting edge. The default gives 1-cycle latency.
- HOLD: out_valid=1. out_sum, out_carry and out_zero hold stable until accepted.
- On out_valid&out_ready, op_count increments (mod 256). Then:
  - if in_valid is also high in the same cycle, load the new operands and go to SETTLE (back-to-back; out_valid drops for N cycles);
  - otherwise clear out_valid and go to IDLE.
- out_sum/out_carry/out_zero retain their last captured values after acceptance. Only out_valid qualifies them.
- alu_x/alu_y/alu_sel change only on an accepting input handshake. They are otherwise held, including in IDLE, so the ALU output stays quiet.
- in_sel is opaque to the sequencer: all 4 bits are registered and forwarded.
- Simultaneous rst with any handshake: rst wins. No capture, no op_count increment, operation dropped.
- rst mid-SETTLE or mid-HOLD: the pending result is discarded and all outputs return to their reset values on that edge.
- in_valid while not ready: no state change. Upstream must hold its data until accepted.
- out_ready with out_valid=0: ignored.
- SETTLE_CYCLES outside 1..15 is illegal; elaboration-time check.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1 -> all outputs 0, in_ready=1, busy=0, no acceptance; after release, in_ready=1.
2. Single op, ALU modelled as adder for sel=0000: x=0x0F, y=0x01, out_ready=1 -> out_valid one cycle after accept, out_sum=0x10, out_carry=0, out_zero=0, op_count=1.
3. Carry/zero: x=0xFF, y=0x01 -> out_sum=0x00, out_carry=1, out_zero=1. Then with SETTLE_CYCLES=4, out_valid rises exactly 4 edges after accept.
4. Backpressure: hold out_ready=0 for 5 cycles with the next op on in_valid -> out_* stable, in_ready=0, alu_x unchanged. Raise out_ready -> result accepted and new op loaded on the same edge; next result correct.
5. Reset mid-SETTLE (SETTLE_CYCLES=3, rst on edge 2) -> out_valid never asserts, op_count stays 0, alu_x=0x00.
6. Stream 257 ops back-to-back with out_ready=1 -> op_count wraps to 0x01, and every result matches the model.
